// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with pending-write scoreboard and zero-init sweep.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rstf,
  output logic              ready,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush
);
  function automatic logic [(1<<AW)-1:0] ok_mask();
    ok_mask = '0;
    for (int r = 1; r < NREGS; r++) ok_mask[r] = 1'b1;
  endfunction
  // addresses that name a real, writable register (excludes r0 and out-of-range)
  localparam logic [(1<<AW)-1:0] ok = ok_mask();
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic run, iss_ok;
  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] busy, busy_nxt, hit;
  logic [NWR-1:0] wv;
  logic [AW-1:0] wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic [AW-1:0] ra [NRD];
  assign run = state == RUN;
  assign ready = run;
  assign iss_ok = run & iss_en & ~flush;
  always_comb begin
    state_nxt = (state == INIT && cnt == AW'(NREGS - 1)) ? RUN : state;
    cnt_nxt = run ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rstf)
    if (!rstf) begin
      state <= INIT;
      cnt <= '0;
      busy <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      busy <= busy_nxt;
    end
  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wa[j] = wr_addr[j*AW +: AW];
      wd[j] = wr_data[j*XLEN +: XLEN];
      wv[j] = run & wr_en[j] & ok[wr_addr[j*AW +: AW]];
    end
    for (int i = 0; i < NRD; i++) ra[i] = rd_addr[i*AW +: AW];
  end
  // a new issue outranks a same-cycle write-back; flush outranks both
  always_comb begin
    hit = '0;
    busy_nxt = busy;
    for (int r = 0; r < NREGS; r++) begin
      for (int j = 0; j < NWR; j++) hit[r] = hit[r] | (wv[j] & (wa[j] == AW'(r)));
      busy_nxt[r] = (iss_ok && iss_addr == AW'(r) && r != 0) ? 1'b1 :
                    ((hit[r] || (run && flush)) ? 1'b0 : busy[r]);
    end
  end
  always_ff @(posedge clk)
    if (!run) mem[cnt] <= '0;
    else for (int j = 0; j < NWR; j++) if (wv[j]) mem[wa[j]] <= wd[j];
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = (run && ok[ra[i]]) ? mem[ra[i]] : '0;
      rd_busy[i] = run & ok[ra[i]] & busy[ra[i]];
`ifdef REGFILE_SB_BYPASS_EN
      for (int j = 0; j < NWR; j++)
        if (wv[j] && wa[j] == ra[i]) begin
          rd_data[i*XLEN +: XLEN] = wd[j];
          rd_busy[i] = iss_ok && iss_addr == ra[i];
        end
`endif
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven directed bench for regfile_sb (default parameters).
module tb_regfile_sb;
  logic clk, rstf, ready, iss_en, flush;
  logic [9:0] rd_addr, wr_addr;
  logic [63:0] rd_data, wr_data;
  logic [1:0] rd_busy, wr_en;
  logic [4:0] iss_addr;
  int n_vec = 0, n_err = 0, edges;
  typedef struct {
    logic [1:0] we;
    logic [4:0] wa0, wa1;
    logic [31:0] wd0, wd1;
    logic ie;
    logic [4:0] ia;
    logic fl;
    logic [4:0] ra0, ra1;
    logic [31:0] ed0, ed1;
    logic [1:0] eb;
  } vec_t;
  vec_t tbl[$];
  regfile_sb dut (
    .clk(clk), .rstf(rstf), .ready(ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic add(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                     input logic [4:0] wa1, input logic [31:0] wd1, input logic ie,
                     input logic [4:0] ia, input logic fl, input logic [4:0] ra0,
                     input logic [4:0] ra1, input logic [31:0] ed0, input logic [31:0] ed1,
                     input logic [1:0] eb);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ie = ie; v.ia = ia; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ed1 = ed1; v.eb = eb;
    tbl.push_back(v);
  endtask
  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0; iss_en = 0; iss_addr = 0; flush = 0;
  endtask
  initial begin
    // expected outputs reflect state before each vector's clock edge
    add(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0);
    add(1, 7, 32'h12345678, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0);
    add(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 7, 0, 32'h12345678, 0);
    add(3, 3, 32'h1, 3, 32'h2, 0, 0, 0, 0, 7, 0, 32'h12345678, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 32'h2, 0, 0);
    add(0, 0, 0, 0, 0, 1, 9, 0, 3, 8, 32'h2, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 9, 7, 0, 32'h12345678, 2'b01);
    add(2, 0, 0, 9, 32'hAA, 0, 0, 0, 3, 7, 32'h2, 32'h12345678, 2'b00);
    add(0, 0, 0, 0, 0, 0, 0, 0, 9, 7, 32'hAA, 32'h12345678, 0);
    add(1, 9, 32'hBB, 0, 0, 1, 9, 0, 3, 7, 32'h2, 32'h12345678, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'hBB, 32'hBB, 2'b11);
    add(0, 0, 0, 0, 0, 1, 4, 0, 9, 3, 32'hBB, 32'h2, 2'b01);
    add(0, 0, 0, 0, 0, 1, 6, 0, 4, 9, 0, 32'hBB, 2'b11);
    add(0, 0, 0, 0, 0, 0, 0, 1, 6, 4, 0, 0, 2'b11);
    add(0, 0, 0, 0, 0, 0, 0, 0, 9, 4, 32'hBB, 0, 0);
    add(0, 0, 0, 0, 0, 1, 12, 1, 6, 12, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 12, 6, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 32'h2, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 32'h2, 0);
    add(3, 31, 32'hCAFE, 1, 32'hBEEF, 0, 0, 0, 2, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 31, 1, 32'hCAFE, 32'hBEEF, 0);
    add(1, 10, 32'h11, 0, 0, 0, 0, 0, 31, 1, 32'hCAFE, 32'hBEEF, 0);
    add(0, 0, 0, 0, 0, 1, 10, 0, 10, 3, 32'h11, 32'h2, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 10, 3, 32'h11, 32'h2, 2'b01);
    rstf = 0; idle(); rd_addr = {5'd7, 5'd5};
    #12;
    chk("reset ready", 32'(ready), 0);
    chk("reset busy", 32'(rd_busy), 0);
    chk("reset data", rd_data[31:0], 0);
    rstf = 1;
    wr_en = 2'b01; wr_addr = 10'd5; wr_data = 64'hDEAD; iss_en = 1; iss_addr = 5; flush = 1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (k == 1) idle();
      chk($sformatf("init ready edge %0d", k), 32'(ready), (k == 32) ? 32'd1 : 32'd0);
    end
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      #1;
      chk($sformatf("zero r%0d", a), rd_data[31:0], 0);
      chk($sformatf("zero r%0d", a + 1), rd_data[63:32], 0);
    end
    @(posedge clk); #1;
    foreach (tbl[k]) begin
      wr_en = tbl[k].we; wr_addr = {tbl[k].wa1, tbl[k].wa0}; wr_data = {tbl[k].wd1, tbl[k].wd0};
      iss_en = tbl[k].ie; iss_addr = tbl[k].ia; flush = tbl[k].fl;
      rd_addr = {tbl[k].ra1, tbl[k].ra0};
      #3;
      chk($sformatf("v%0d d0", k), rd_data[31:0], tbl[k].ed0);
      chk($sformatf("v%0d d1", k), rd_data[63:32], tbl[k].ed1);
      chk($sformatf("v%0d busy", k), 32'(rd_busy), 32'(tbl[k].eb));
      @(posedge clk); #1;
    end
    wr_en = 2'b10; wr_addr = {5'd10, 5'd0}; wr_data = {32'h55, 32'h0}; rd_addr = {5'd3, 5'd10};
    #3;
`ifdef REGFILE_SB_BYPASS_EN
    chk("bypass data", rd_data[31:0], 32'h55);
    chk("bypass busy", 32'(rd_busy[0]), 0);
`else
    chk("nobypass data", rd_data[31:0], 32'h11);
    chk("nobypass busy", 32'(rd_busy[0]), 1);
`endif
    @(posedge clk); #1;
    idle();
    #1;
    chk("post write data", rd_data[31:0], 32'h55);
    chk("post write busy", 32'(rd_busy[0]), 0);
    iss_en = 1; iss_addr = 10;
    @(posedge clk); #1;
    idle();
    #1;
    chk("reissue busy", 32'(rd_busy[0]), 1);
    #2 rstf = 0;
    #1;
    chk("midrun reset ready", 32'(ready), 0);
    chk("midrun reset busy", 32'(rd_busy), 0);
    chk("midrun reset data", rd_data[31:0], 0);
    #1 rstf = 1;
    edges = 0;
    while (!ready && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("reinit edges", 32'(edges), 32);
    chk("reinit r10 data", rd_data[31:0], 0);
    chk("reinit r10 busy", 32'(rd_busy[0]), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
